// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single halfword-wide memory.
// Port 0 is the CPU path, port 1 the debug/loader path. Byte, halfword and
// word requests become one or two halfword beats; words are big-endian
// (upper halfword at the lower address). Round-robin on conflict.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, arbitrates and latches the winner
// BEAT0 | first (or only) memory beat on the bus
// BEAT1 | second beat of a word access, upper read halfword captured
// WAIT  | read data from the last beat is captured
// ACK   | one-cycle acknowledge to the owner, then back to IDLE
module mem_arbiter #(
  parameter int MEM_DEPTH = 4096,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_we,
  input  logic [1:0]            i_size0,
  input  logic [1:0]            i_size1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [31:0]           i_wdata0,
  input  logic [31:0]           i_wdata1,
  output logic [31:0]           o_rdata,
  output logic [1:0]            o_ack,
  output logic [1:0]            o_gnt,
  input  logic [0:1][7:0]       i_mem_do,
  output logic [0:1][7:0]       o_mem_di,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  output logic [0:1]            o_mem_wr_en
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BEAT0 = 3'd1;
  localparam logic [2:0] BEAT1 = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;

  logic [2:0]  state;
  logic        owner;
  logic        last;
  logic        we_q;
  logic [1:0]  size_q;
  logic        addr_lsb;
  logic [15:0] wdata_lo;
  logic [15:0] rdata_hi;

  logic                  sel_port;
  logic                  sel_we;
  logic [1:0]            sel_size;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [15:0]           beat0_di;
  logic [0:1]            beat0_wr;

  // Arbitration: on conflict the port that did not win last time goes next.
  always_comb begin
    sel_port = 1'b0;
    if (i_req == 2'b11) sel_port = ~last;
    else                sel_port = i_req[1];
    sel_we    = sel_port ? i_we[1]  : i_we[0];
    sel_size  = sel_port ? i_size1  : i_size0;
    sel_addr  = sel_port ? i_addr1  : i_addr0;
    sel_wdata = sel_port ? i_wdata1 : i_wdata0;
  end

  // First-beat write lanes; bytes are replicated so either lane can take them.
  always_comb begin
    beat0_di = 16'h0000;
    beat0_wr = 2'b00;
    if (sel_we) begin
      case (sel_size)
        2'b00: begin
          beat0_di = {2{sel_wdata[7:0]}};
          beat0_wr = sel_addr[0] ? 2'b01 : 2'b10;
        end
        2'b01: begin
          beat0_di = sel_wdata[15:0];
          beat0_wr = 2'b11;
        end
        default: begin
          beat0_di = sel_wdata[31:16];
          beat0_wr = 2'b11;
        end
      endcase
    end
  end

  // Sequencer; every output is set one cycle ahead so all of them come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_lsb    <= 1'b0;
      wdata_lo    <= 16'h0000;
      rdata_hi    <= 16'h0000;
      o_rdata     <= 32'h0;
      o_ack       <= 2'b00;
      o_gnt       <= 2'b00;
      o_mem_di    <= 16'h0000;
      o_mem_addr  <= '0;
      o_mem_en    <= 1'b0;
      o_mem_rd_en <= 1'b0;
      o_mem_wr_en <= 2'b00;
    end else begin
      o_ack <= 2'b00;
      case (state)
        IDLE: begin
          if (|i_req) begin
            owner       <= sel_port;
            last        <= sel_port;
            we_q        <= sel_we;
            size_q      <= sel_size;
            addr_lsb    <= sel_addr[0];
            wdata_lo    <= sel_wdata[15:0];
            o_gnt       <= sel_port ? 2'b10 : 2'b01;
            o_rdata     <= 32'h0;
            o_mem_en    <= 1'b1;
            o_mem_rd_en <= ~sel_we;
            o_mem_wr_en <= beat0_wr;
            o_mem_di    <= beat0_di;
            o_mem_addr  <= {sel_addr[ADDR_WIDTH-1:1], 1'b0};
            state       <= BEAT0;
          end
        end
        BEAT0: begin
          if (size_q[1]) begin
            // Second beat of a word; the address wraps at the top of memory.
            o_mem_addr  <= o_mem_addr + ADDR_WIDTH'(2);
            o_mem_wr_en <= we_q ? 2'b11 : 2'b00;
            o_mem_di    <= we_q ? wdata_lo : 16'h0000;
            state       <= BEAT1;
          end else begin
            o_mem_en    <= 1'b0;
            o_mem_rd_en <= 1'b0;
            o_mem_wr_en <= 2'b00;
            o_mem_di    <= 16'h0000;
            if (we_q) begin
              o_ack <= owner ? 2'b10 : 2'b01;
              state <= ACK;
            end else begin
              state <= WAIT;
            end
          end
        end
        BEAT1: begin
          rdata_hi    <= i_mem_do;
          o_mem_en    <= 1'b0;
          o_mem_rd_en <= 1'b0;
          o_mem_wr_en <= 2'b00;
          o_mem_di    <= 16'h0000;
          if (we_q) begin
            o_ack <= owner ? 2'b10 : 2'b01;
            state <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          case (size_q)
            2'b00:   o_rdata <= {24'h0, addr_lsb ? i_mem_do[1] : i_mem_do[0]};
            2'b01:   o_rdata <= {16'h0, i_mem_do};
            default: o_rdata <= {rdata_hi, i_mem_do};
          endcase
          o_ack <= owner ? 2'b10 : 2'b01;
          state <= ACK;
        end
        ACK: begin
          o_gnt   <= 2'b00;
          o_rdata <= 32'h0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory behind the port, byte-level
// reference memory for expected read data, table vectors, corner sequences
// and a randomized phase.
module tb_mem_arbiter;
  localparam int AW = 13;
  localparam int MEM_BYTES = 8192;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, we, size0, size1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0] wdata0, wdata1, rdata;
  logic [1:0] ack, gnt;
  logic [0:1][7:0] mem_do, mem_di;
  logic [AW-1:0] mem_addr;
  logic mem_en, mem_rd_en;
  logic [0:1] mem_wr_en;

  logic [7:0] pm [0:MEM_BYTES-1];
  logic [7:0] shadow [0:MEM_BYTES-1];
  logic load;

  int n_pass = 0;
  int n_total = 0;

  logic [AW-1:0] beat_addr [0:3];
  logic [15:0] beat_di [0:3];
  logic [1:0] beat_wr [0:3];
  logic beat_rd [0:3];
  int nbeats;
  int res_lat;
  logic [1:0] res_ack;
  logic [31:0] res_rdata;

  typedef struct {
    logic p;
    logic w;
    logic [1:0] s;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    int exp_lat;
  } vec_t;
  vec_t vecs [0:13];

  mem_arbiter #(.MEM_DEPTH(4096)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we),
    .i_size0(size0), .i_size1(size1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_rdata(rdata), .o_ack(ack),
    .o_gnt(gnt), .i_mem_do(mem_do), .o_mem_di(mem_di), .o_mem_addr(mem_addr),
    .o_mem_en(mem_en), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en)
  );

  always #5 clk = ~clk;

  // Memory: read data appears the cycle after a read beat, otherwise junk.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < MEM_BYTES; i++) pm[i] <= shadow[i];
    end else if (mem_en) begin
      if (mem_wr_en[0]) pm[{mem_addr[AW-1:1], 1'b0}] <= mem_di[0];
      if (mem_wr_en[1]) pm[{mem_addr[AW-1:1], 1'b1}] <= mem_di[1];
    end
    if (!load && mem_en && mem_rd_en)
      mem_do <= {pm[{mem_addr[AW-1:1], 1'b0}], pm[{mem_addr[AW-1:1], 1'b1}]};
    else
      mem_do <= 16'($urandom);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, words big-endian, wrapping.
  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input logic [1:0] s);
    logic [AW-1:0] b0, b1, b2, b3;
    b0 = {a[AW-1:1], 1'b0};
    b1 = b0 + 13'd1;
    b2 = b0 + 13'd2;
    b3 = b0 + 13'd3;
    if (s == 2'b00) return {24'h0, shadow[a]};
    if (s == 2'b01) return {16'h0, shadow[b0], shadow[b1]};
    return {shadow[b0], shadow[b1], shadow[b2], shadow[b3]};
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [AW-1:0] b0, b1, b2, b3;
    b0 = {a[AW-1:1], 1'b0};
    b1 = b0 + 13'd1;
    b2 = b0 + 13'd2;
    b3 = b0 + 13'd3;
    if (s == 2'b00) shadow[a] = d[7:0];
    else if (s == 2'b01) begin
      shadow[b0] = d[15:8];
      shadow[b1] = d[7:0];
    end else begin
      shadow[b0] = d[31:24];
      shadow[b1] = d[23:16];
      shadow[b2] = d[15:8];
      shadow[b3] = d[7:0];
    end
  endtask

  // One transaction from an idle arbiter; checks ack, latency, data, grant, beats.
  task automatic do_txn(input logic p, input logic w, input logic [1:0] s,
                        input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    int exp_lat;
    logic [1:0] oh, g1;
    int di_bad;
    exp_rd = w ? 32'h0 : model_read(a, s);
    exp_lat = (w ? 2 : 3) + (s[1] ? 1 : 0);
    oh = p ? 2'b10 : 2'b01;
    @(negedge clk);
    if (!p) begin we[0] = w; size0 = s; addr0 = a; wdata0 = d; end
    else begin we[1] = w; size1 = s; addr1 = a; wdata1 = d; end
    req[p] = 1'b1;
    @(posedge clk);
    res_lat = 0; res_ack = 2'b00; res_rdata = 32'h0;
    nbeats = 0; di_bad = 0; g1 = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (k == 1) begin
        g1 = gnt;
        if (!p) begin
          we[0] = 1'($urandom); size0 = 2'($urandom); addr0 = 13'($urandom); wdata0 = $urandom;
        end else begin
          we[1] = 1'($urandom); size1 = 2'($urandom); addr1 = 13'($urandom); wdata1 = $urandom;
        end
      end
      if (mem_en && nbeats < 4) begin
        beat_addr[nbeats] = mem_addr;
        beat_di[nbeats] = mem_di;
        beat_wr[nbeats] = mem_wr_en;
        beat_rd[nbeats] = mem_rd_en;
        nbeats++;
      end
      if (mem_wr_en == 2'b00 && mem_di != 16'h0) di_bad++;
      if (ack != 2'b00) begin
        res_lat = k; res_ack = ack; res_rdata = rdata;
        break;
      end
      @(posedge clk);
    end
    req[p] = 1'b0;
    @(posedge clk);
    if (w) model_write(a, s, d);
    check("ack_port", 32'(res_ack), 32'(oh));
    check("latency", res_lat, exp_lat);
    check("rdata", res_rdata, exp_rd);
    check("gnt", 32'(g1), 32'(oh));
    check("beats", nbeats, s[1] ? 2 : 1);
    check("di_idle", di_bad, 0);
  endtask

  initial begin
    int ack_port [0:5];
    int ack_cyc [0:5];
    logic [31:0] ack_rd [0:5];
    int nack, overlap, seen, bad;
    logic p, w;
    logic [1:0] s;
    logic [AW-1:0] a;

    for (int i = 0; i < MEM_BYTES; i++) shadow[i] = 8'(i);
    shadow[13'h0010] = 8'hAB; shadow[13'h0011] = 8'hCD;
    shadow[13'h0030] = 8'h12; shadow[13'h0031] = 8'h34;
    shadow[13'h1FFE] = 8'hDE; shadow[13'h1FFF] = 8'hAD;

    rst = 1'b1; load = 1'b1; req = 2'b00; we = 2'b00;
    size0 = 2'b01; size1 = 2'b01; addr0 = 13'h0010; addr1 = 13'h0030;
    wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    load = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ack_gnt", {28'h0, ack, gnt}, 32'h0);
    check("rst_mem_ctl", {28'h0, mem_en, mem_rd_en, mem_wr_en}, 32'h0);
    check("rst_mem_di", 32'(mem_di), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Both ports hammering halfword reads straight out of reset.
    @(negedge clk);
    rst = 1'b0; req = 2'b11;
    nack = 0; overlap = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (ack != 2'b00) begin
        if (ack == 2'b11) overlap++;
        if (nack < 6) begin
          ack_port[nack] = ack[1] ? 1 : 0;
          ack_cyc[nack] = cyc;
          ack_rd[nack] = rdata;
          nack++;
        end
      end
    end
    check("rr_count", nack, 6);
    check("rr_overlap", overlap, 0);
    check("rr_first_cycle", ack_cyc[0], 3);
    for (int i = 0; i < 6; i++) begin
      check("rr_port", ack_port[i], i % 2);
      check("rr_rdata", ack_rd[i], (i % 2) ? model_read(13'h0030, 2'b01) : model_read(13'h0010, 2'b01));
      if (i > 0) check("rr_gap", ack_cyc[i] - ack_cyc[i-1], 4);
    end
    @(negedge clk);
    req = 2'b00; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 1'b0, 2'b01, 13'h0010, 32'h0,        32'h0000ABCD, 3};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 13'h0020, 32'h11223344, 32'h0,        3};
    vecs[2]  = '{1'b0, 1'b0, 2'b10, 13'h0020, 32'h0,        32'h11223344, 4};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 13'h0031, 32'h0,        32'h00000034, 3};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 13'h0030, 32'h0,        32'h00000012, 3};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 13'h0031, 32'hFFFFFF5A, 32'h0,        2};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 13'h0031, 32'h0,        32'h0000125A, 3};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 13'h0041, 32'h1234BEEF, 32'h0,        2};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 13'h0040, 32'h0,        32'hBEEF4243, 4};
    vecs[9]  = '{1'b0, 1'b0, 2'b10, 13'h1FFE, 32'h0,        32'hDEAD0001, 4};
    vecs[10] = '{1'b1, 1'b1, 2'b11, 13'h0050, 32'hCAFEF00D, 32'h0,        3};
    vecs[11] = '{1'b0, 1'b0, 2'b10, 13'h0051, 32'h0,        32'hCAFEF00D, 4};
    vecs[12] = '{1'b1, 1'b1, 2'b00, 13'h0060, 32'h000000A5, 32'h0,        2};
    vecs[13] = '{1'b0, 1'b0, 2'b01, 13'h0060, 32'h0,        32'h0000A561, 3};
    for (int i = 0; i < 14; i++) begin
      do_txn(vecs[i].p, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d);
      check("vec_rdata", res_rdata, vecs[i].exp_rdata);
      check("vec_latency", res_lat, vecs[i].exp_lat);
    end

    do_txn(1'b1, 1'b1, 2'b10, 13'h0020, 32'h11223344);
    check("ww_addr0", 32'(beat_addr[0]), 32'h0020);
    check("ww_di0", 32'(beat_di[0]), 32'h1122);
    check("ww_wr0", 32'(beat_wr[0]), 32'h3);
    check("ww_addr1", 32'(beat_addr[1]), 32'h0022);
    check("ww_di1", 32'(beat_di[1]), 32'h3344);
    check("ww_wr1", 32'(beat_wr[1]), 32'h3);

    do_txn(1'b0, 1'b1, 2'b00, 13'h0031, 32'h0000005A);
    check("bw_addr", 32'(beat_addr[0]), 32'h0030);
    check("bw_wr", 32'(beat_wr[0]), 32'h1);
    check("bw_di", 32'(beat_di[0]), 32'h5A5A);

    do_txn(1'b0, 1'b0, 2'b01, 13'h0010, 32'h0);
    check("hr_rd_en", 32'(beat_rd[0]), 32'h1);
    check("hr_wr", 32'(beat_wr[0]), 32'h0);

    do_txn(1'b1, 1'b0, 2'b10, 13'h1FFE, 32'h0);
    check("top_addr0", 32'(beat_addr[0]), 32'h1FFE);
    check("top_addr1", 32'(beat_addr[1]), 32'h0000);
    check("top_rd1", 32'(beat_rd[1]), 32'h1);

    // Reset landing during the second beat of a word write.
    @(negedge clk);
    we[0] = 1'b1; size0 = 2'b10; addr0 = 13'h0100; wdata0 = 32'h99887766; req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_beat1_addr", 32'(mem_addr), 32'h0102);
    rst = 1'b1; req = 2'b00;
    @(posedge clk); #1;
    check("abort_rdata", rdata, 32'h0);
    check("abort_ctl", {28'h0, ack, gnt}, 32'h0);
    check("abort_mem_ctl", {28'h0, mem_en, mem_rd_en, mem_wr_en}, 32'h0);
    check("abort_mem_di", 32'(mem_di), 32'h0);
    check("abort_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack != 2'b00 || mem_en) seen++;
    end
    check("abort_quiet", seen, 0);
    model_write(13'h0100, 2'b10, 32'h99887766);
    do_txn(1'b0, 1'b0, 2'b10, 13'h0100, 32'h0);

    for (int n = 0; n < 150; n++) begin
      p = 1'($urandom);
      w = 1'($urandom);
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 13'h1FFE | 13'($urandom_range(0, 1));
      else a = 13'($urandom);
      do_txn(p, w, s, a, $urandom);
    end

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (pm[i] !== shadow[i]) bad++;
    check("mem_image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
